writeback_stage: RTL
====================

// Module: writeback_stage
// PURPOSE
//  Final pipeline stage: commits ALU results or load data to the register file, one write per cycle max.
//  Successor to the fixed-width writeback: XLEN-parametrised, valid/ready input, variable-latency load wait.
//  Performs load byte/half/word selection and sign/zero extension, suppresses x0 and invalid writes.
//  Drives a forwarding port for the decode/execute bypass network and flags load timeouts.
// PARAMETERS
//  XLEN          32   datapath width; legal values 32 or 64
//  REG_ADDR_W    5    register index width
//  LOAD_TIMEOUT  16   max cycles in WAIT_LOAD before abort; >=2
// PORTS
//  clk           in   1           clock, all state on rising edge
//  rst           in   1           asynchronous, active-high reset
//  in_valid_i    in   1           upstream instruction valid
//  in_ready_o    out  1           stage can accept; combinational, =(state==IDLE)
//  sel_rd_i      in   REG_ADDR_W  destination register
//  rd_en_i       in   1           instruction writes rd
//  mem_re_i      in   1           instruction is a load
//  funct3_i      in   3           load type (RISC-V encoding)
//  addr_lo_i     in   $clog2(XLEN/8)  low bits of load address
//  alu_result_i  in   XLEN        non-load result
//  mem_rvalid_i  in   1           load data valid (may coincide with issue cycle)
//  mem_rdata_i   in   XLEN        raw aligned memory word
//  we_o          out  1           registered RF write enable, single-cycle pulse
//  sel_rd_o      out  REG_ADDR_W  registered RF write index
//  data_o        out  XLEN        registered RF write data
//  fwd_valid_o   out  1           =we_o; fwd_sel_rd_o/fwd_data_o mirror sel_rd_o/data_o
//  fwd_sel_rd_o  out  REG_ADDR_W  bypass index
//  fwd_data_o    out  XLEN        bypass data
//  load_err_o    out  1           one-cycle pulse on load timeout
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, we_o/sel_rd_o/data_o/load_err_o=0; reset mid-load aborts, no write issued.
//  Accept = in_valid_i && in_ready_o. Write-qualify: wr = rd_en_i && sel_rd_i!=0.
//  IDLE, accept, !mem_re_i: next cycle we_o=wr, sel_rd_o=sel_rd_i, data_o=alu_result_i. Latency 1.
//  IDLE, accept, mem_re_i, mem_rvalid_i=1: next cycle write extracted data; stay IDLE. Latency 1.
//  IDLE, accept, mem_re_i, mem_rvalid_i=0: latch rd/wr/funct3/addr_lo, counter=0, go WAIT_LOAD.
//  WAIT_LOAD: in_ready_o=0; counter++ each cycle. mem_rvalid_i=1 -> next cycle write, go IDLE.
//  WAIT_LOAD, counter==LOAD_TIMEOUT-1 and !mem_rvalid_i -> next cycle load_err_o=1, we_o=0, go IDLE.
//  rvalid on the timeout cycle wins (write, no error). mem_rvalid_i in IDLE without a load accept: ignored.
//  we_o is 0 on every cycle not completing a qualified write; sel_rd_o/data_o hold last value.
//  Extraction (lane = addr_lo): 000 LB sext byte[lane]; 100 LBU zext byte[lane];
//   001 LH sext half[lane>>1]; 101 LHU zext half[lane>>1]; 010 LW sext word[lane>>2];
//   110 LWU zext word (XLEN=64 only); 011 LD full (XLEN=64 only); any other code -> full word unmodified.
//  Misaligned low address bits within the selected element are ignored (alignment trapped upstream).
// STRUCTURE
//  wb_pkg: wb_state_e {IDLE, WAIT_LOAD}; load_funct3_e constants (LB..LWU); counter width function.
//  Sub-module load_extract: combinational (funct3, addr_lo, rdata) -> XLEN result; shared by both load paths.
//  Top: FSM, timeout counter, latched load context, output registers.
// TESTING
//  ALU op rd=5, rd_en=1, alu=0xDEADBEEF -> next cycle we_o=1, sel_rd_o=5, data_o=0xDEADBEEF, fwd equal.
//  ALU op rd=0, rd_en=1 -> we_o stays 0; rd_en=0, rd=7 -> we_o stays 0.
//  LB addr_lo=3, rdata=0x80112233 same cycle -> data_o=0xFFFFFF80; LBU -> 0x00000080; LHU addr_lo=2 -> 0x00008011.
//  LW, rvalid 4 cycles later -> in_ready_o=0 for 4 cycles, then write, in_ready_o=1 in the write cycle.
//  LW with no rvalid, LOAD_TIMEOUT=16 -> load_err_o pulses after 16 WAIT cycles, we_o=0, back to IDLE.
//  rst asserted during WAIT_LOAD, then late rvalid -> no write, in_ready_o=1 after release; XLEN=64 LD/LWU checked.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback stage.
// Covers the FSM states, the RISC-V load funct3 codes and the sizing of the load-timeout counter.
package wb_pkg;

  typedef enum logic {
    IDLE,
    WAIT_LOAD
  } wb_state_e;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110
  } load_funct3_e;

  // The counter only has to reach timeout-1.
  function automatic int cnt_width(int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/wb_if.sv
// Upstream/memory/register-file bundle of the writeback stage.
// The master modport is the pipeline side; the slave modport is the stage itself.
interface wb_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  localparam int AW = $clog2(XLEN / 8);

  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [REG_ADDR_W-1:0] sel_rd_i;
  logic                  rd_en_i;
  logic                  mem_re_i;
  logic [2:0]            funct3_i;
  logic [AW-1:0]         addr_lo_i;
  logic [XLEN-1:0]       alu_result_i;
  logic                  mem_rvalid_i;
  logic [XLEN-1:0]       mem_rdata_i;
  logic                  we_o;
  logic [REG_ADDR_W-1:0] sel_rd_o;
  logic [XLEN-1:0]       data_o;
  logic                  fwd_valid_o;
  logic [REG_ADDR_W-1:0] fwd_sel_rd_o;
  logic [XLEN-1:0]       fwd_data_o;
  logic                  load_err_o;

  modport master (
    output in_valid_i, sel_rd_i, rd_en_i, mem_re_i, funct3_i, addr_lo_i,
           alu_result_i, mem_rvalid_i, mem_rdata_i,
    input  in_ready_o, we_o, sel_rd_o, data_o, fwd_valid_o, fwd_sel_rd_o,
           fwd_data_o, load_err_o
  );

  modport slave (
    input  in_valid_i, sel_rd_i, rd_en_i, mem_re_i, funct3_i, addr_lo_i,
           alu_result_i, mem_rvalid_i, mem_rdata_i,
    output in_ready_o, we_o, sel_rd_o, data_o, fwd_valid_o, fwd_sel_rd_o,
           fwd_data_o, load_err_o
  );

endinterface

// File: rtl/load_extract.sv
// Combinational load-data selection: picks byte/half/word from the raw memory word
// and sign- or zero-extends it to XLEN according to the RISC-V funct3 code.
module load_extract
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]               funct3,
  input  logic [$clog2(XLEN/8)-1:0] addr_lo,
  input  logic [XLEN-1:0]          rdata,
  output logic [XLEN-1:0]          result
);
  localparam int AW = $clog2(XLEN / 8);

  logic [AW-1:0]      lo_h;
  logic [AW-1:0]      lo_w;
  logic signed [7:0]  byte_v;
  logic signed [15:0] half_v;
  logic signed [31:0] word_v;

  // Clearing the low address bits ignores misalignment inside the selected element.
  assign lo_h   = addr_lo & ~AW'(1);
  assign lo_w   = addr_lo & ~AW'(3);
  assign byte_v = 8'(rdata >> {addr_lo, 3'b000});
  assign half_v = 16'(rdata >> {lo_h, 3'b000});
  assign word_v = 32'(rdata >> {lo_w, 3'b000});

  always_comb begin
    result = rdata;
    case (funct3)
      F3_LB:  result = XLEN'(byte_v);
      F3_LBU: result = XLEN'($unsigned(byte_v));
      F3_LH:  result = XLEN'(half_v);
      F3_LHU: result = XLEN'($unsigned(half_v));
      F3_LW:  result = XLEN'(word_v);
      F3_LWU: if (XLEN == 64) result = XLEN'($unsigned(word_v));
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: commits ALU results or extracted load data to the register file,
// waits for late load data with a bounded timeout, and mirrors each write on the bypass port.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  wb_if.slave  bus
);
  localparam int AW = $clog2(XLEN / 8);
  localparam int CW = cnt_width(LOAD_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOAD_TIMEOUT - 1);

  wb_state_e             state;
  logic [CW-1:0]         cnt;
  logic [REG_ADDR_W-1:0] pend_rd;
  logic                  pend_wr;
  logic [2:0]            pend_f3;
  logic [AW-1:0]         pend_lo;

  logic                  we_q;
  logic                  err_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [XLEN-1:0]       data_q;

  logic                  accept;
  logic                  wr_qual;
  logic [2:0]            ext_f3;
  logic [AW-1:0]         ext_lo;
  logic [XLEN-1:0]       ext_data;

  assign bus.in_ready_o = (state == IDLE);
  assign accept         = bus.in_valid_i && (state == IDLE);
  assign wr_qual        = bus.rd_en_i && (bus.sel_rd_i != '0);

  // One extractor serves both paths: live inputs on the issue cycle, latched context while waiting.
  assign ext_f3 = (state == IDLE) ? bus.funct3_i  : pend_f3;
  assign ext_lo = (state == IDLE) ? bus.addr_lo_i : pend_lo;

  load_extract #(
    .XLEN (XLEN)
  ) u_load_extract (
    .funct3  (ext_f3),
    .addr_lo (ext_lo),
    .rdata   (bus.mem_rdata_i),
    .result  (ext_data)
  );

  // sel_rd/data only move on a qualified write so they hold across suppressed ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pend_rd <= '0;
      pend_wr <= 1'b0;
      pend_f3 <= '0;
      pend_lo <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      we_q  <= 1'b0;
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!bus.mem_re_i) begin
              we_q <= wr_qual;
              if (wr_qual) begin
                rd_q   <= bus.sel_rd_i;
                data_q <= bus.alu_result_i;
              end
            end else if (bus.mem_rvalid_i) begin
              we_q <= wr_qual;
              if (wr_qual) begin
                rd_q   <= bus.sel_rd_i;
                data_q <= ext_data;
              end
            end else begin
              pend_rd <= bus.sel_rd_i;
              pend_wr <= wr_qual;
              pend_f3 <= bus.funct3_i;
              pend_lo <= bus.addr_lo_i;
              cnt     <= '0;
              state   <= WAIT_LOAD;
            end
          end
        end
        WAIT_LOAD: begin
          if (bus.mem_rvalid_i) begin
            we_q <= pend_wr;
            if (pend_wr) begin
              rd_q   <= pend_rd;
              data_q <= ext_data;
            end
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            err_q <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.we_o         = we_q;
  assign bus.sel_rd_o     = rd_q;
  assign bus.data_o       = data_q;
  assign bus.fwd_valid_o  = we_q;
  assign bus.fwd_sel_rd_o = rd_q;
  assign bus.fwd_data_o   = data_q;
  assign bus.load_err_o   = err_q;

endmodule
